// File: rtl/axi_w_downsizer.sv
// Wide-to-narrow AXI W converter: queues write commands and slices each wide beat
// into narrow lanes chosen by address and size. Emits its own s_wlast_o.
module axi_w_downsizer_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             aclk,
   input  logic             arst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             full_q;
   logic             empty_q;
   logic             do_push;
   logic             do_pop;

   // Ready is the registered full flag only, so a full FIFO refuses a push even when popped.
   assign do_push = push_i && !full_q;
   assign do_pop  = pop_i && !empty_q;

   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge aclk or negedge arst_n) begin
      if (!arst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         count_q <= count_d;
         full_q  <= (count_d == CNT_W'(DEPTH));
         empty_q <= (count_d == '0);
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = full_q;
   assign empty_o = empty_q;
endmodule

module axi_w_downsizer #(
   parameter int M_DATA_WIDTH = 128,
   parameter int S_DATA_WIDTH = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int LEN_WIDTH    = 8,
   parameter int SIZE_WIDTH   = 3,
   parameter int CMD_DEPTH    = 4
) (
   input  logic                      aclk,
   input  logic                      arst_n,
   input  logic                      cmd_valid_i,
   output logic                      cmd_ready_o,
   input  logic [ADDR_WIDTH-1:0]     cmd_addr_i,
   input  logic [LEN_WIDTH-1:0]      cmd_len_i,
   input  logic [SIZE_WIDTH-1:0]     cmd_size_i,
   input  logic [M_DATA_WIDTH-1:0]   m_wdata_i,
   input  logic [M_DATA_WIDTH/8-1:0] m_wstrb_i,
   input  logic                      m_wlast_i,
   input  logic                      m_wvalid_i,
   output logic                      m_wready_o,
   output logic [S_DATA_WIDTH-1:0]   s_wdata_o,
   output logic [S_DATA_WIDTH/8-1:0] s_wstrb_o,
   output logic                      s_wlast_o,
   output logic                      s_wvalid_o,
   input  logic                      s_wready_i,
   output logic                      err_wlast_o
);
   localparam int MB     = M_DATA_WIDTH / 8;
   localparam int SB     = S_DATA_WIDTH / 8;
   localparam int R      = MB / SB;
   localparam int LOG_MB = $clog2(MB);
   localparam int LOG_SB = $clog2(SB);
   localparam int OFF_W  = LOG_MB + 1;
   localparam int LANE_W = (R > 1) ? $clog2(R) : 1;

   typedef enum logic [1:0] {IDLE, ACTIVE, EMIT} state_t;

   typedef struct packed {
      logic [OFF_W-1:0]      off;
      logic [LEN_WIDTH-1:0]  len;
      logic [SIZE_WIDTH-1:0] size;
   } cmd_t;

   function automatic logic [LANE_W-1:0] lane_of(input logic [OFF_W-1:0] off);
      return LANE_W'(off >> LOG_SB);
   endfunction

   cmd_t                    cmd_in;
   cmd_t                    cmd_head;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    pop;
   logic                    unused_addr_hi;

   state_t                  state_q;
   logic [LEN_WIDTH-1:0]    beat_cnt_q;
   logic [OFF_W-1:0]        beat_off_q;
   logic [SIZE_WIDTH-1:0]   size_q;
   logic [LANE_W-1:0]       lane_q;
   logic [M_DATA_WIDTH-1:0] hold_data_q;
   logic [MB-1:0]           hold_strb_q;
   logic                    err_wlast_q;

   logic [OFF_W-1:0]        bytes;
   logic [OFF_W-1:0]        aligned;
   logic [OFF_W-1:0]        end_off;
   logic [OFF_W-1:0]        next_off;
   logic [LANE_W-1:0]       end_lane;
   logic                    last_narrow;
   logic                    accept;
   logic                    acc_final;

   assign unused_addr_hi = ^cmd_addr_i[ADDR_WIDTH-1:OFF_W];

   always_comb begin
      cmd_in      = '0;
      cmd_in.off  = cmd_addr_i[OFF_W-1:0] & OFF_W'(MB - 1);
      cmd_in.len  = cmd_len_i;
      cmd_in.size = (cmd_size_i > SIZE_WIDTH'(LOG_MB)) ? SIZE_WIDTH'(LOG_MB) : cmd_size_i;
   end

   axi_w_downsizer_fifo #(
      .WIDTH($bits(cmd_t)),
      .DEPTH(CMD_DEPTH)
   ) u_cmd_fifo (
      .aclk    (aclk),
      .arst_n  (arst_n),
      .push_i  (cmd_valid_i),
      .wdata_i (cmd_in),
      .pop_i   (pop),
      .rdata_o (cmd_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign cmd_ready_o = !fifo_full;
   assign pop         = (state_q == IDLE) && !fifo_empty;

   // Sub-lane sizes give one narrow beat per wide beat; wider sizes walk the aligned group.
   always_comb begin
      bytes    = OFF_W'(1) << size_q;
      aligned  = beat_off_q & ~(bytes - OFF_W'(1));
      next_off = (aligned + bytes) & OFF_W'(MB - 1);
      end_off  = (size_q >= SIZE_WIDTH'(LOG_SB)) ? (aligned + bytes - OFF_W'(1)) : beat_off_q;
      end_lane = lane_of(end_off);
   end

   assign last_narrow = (lane_q == end_lane);

   // Chained accept on the closing narrow beat keeps the narrow side busy every cycle.
   assign m_wready_o = (state_q == ACTIVE) ||
                       ((state_q == EMIT) && s_wready_i && last_narrow && (beat_cnt_q != '0));
   assign accept     = m_wvalid_i && m_wready_o;
   assign acc_final  = (state_q == ACTIVE) ? (beat_cnt_q == '0) : (beat_cnt_q == LEN_WIDTH'(1));

   always_ff @(posedge aclk or negedge arst_n) begin
      if (!arst_n) begin
         state_q     <= IDLE;
         beat_cnt_q  <= '0;
         beat_off_q  <= '0;
         size_q      <= '0;
         lane_q      <= '0;
         hold_data_q <= '0;
         hold_strb_q <= '0;
         err_wlast_q <= 1'b0;
      end else begin
         err_wlast_q <= accept && (m_wlast_i != acc_final);
         if (accept) begin
            hold_data_q <= m_wdata_i;
            hold_strb_q <= m_wstrb_i;
         end
         case (state_q)
            IDLE: begin
               if (pop) begin
                  beat_cnt_q <= cmd_head.len;
                  beat_off_q <= cmd_head.off;
                  size_q     <= cmd_head.size;
                  state_q    <= ACTIVE;
               end
            end
            ACTIVE: begin
               if (accept) begin
                  lane_q  <= lane_of(beat_off_q);
                  state_q <= EMIT;
               end
            end
            EMIT: begin
               if (s_wready_i) begin
                  if (!last_narrow) begin
                     lane_q <= lane_q + LANE_W'(1);
                  end else if (beat_cnt_q == '0) begin
                     state_q <= IDLE;
                  end else begin
                     beat_cnt_q <= beat_cnt_q - LEN_WIDTH'(1);
                     beat_off_q <= next_off;
                     if (accept) begin
                        lane_q <= lane_of(next_off);
                     end else begin
                        state_q <= ACTIVE;
                     end
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      s_wdata_o = hold_data_q[int'(lane_q) * S_DATA_WIDTH +: S_DATA_WIDTH];
      s_wstrb_o = hold_strb_q[int'(lane_q) * SB +: SB];
   end

   assign s_wvalid_o  = (state_q == EMIT);
   assign s_wlast_o   = (state_q == EMIT) && last_narrow && (beat_cnt_q == '0);
   assign err_wlast_o = err_wlast_q;
endmodule
